// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  // Ceiling log2, floored at 1 so index vectors never collapse to zero width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo NREQ.
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [clog2(NREQ)-1:0]  last,
  output logic                    any,
  output logic [clog2(NREQ)-1:0]  idx
);

  localparam int unsigned IDW = clog2(NREQ);

  int unsigned pos;

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      pos = 32'(last) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any && req[IDW'(pos)]) begin
        any = 1'b1;
        idx = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters,
// with registered operands and a captured valid/ready response.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned NREQ   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*SEL_W-1:0]    req_sel,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_carry,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic                     alu_carry,
  output logic                     busy,
  output logic [clog2(NREQ)-1:0]   grant_id
);

  localparam int unsigned IDW = clog2(NREQ);

  state_e              state_q, state_d;
  logic [IDW-1:0]      last_q, last_d;
  logic [IDW-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_carry_q, rsp_carry_d;

  logic                pick_any;
  logic [IDW-1:0]      pick_idx;
  logic [NREQ-1:0]     pick_oh;
  logic [NREQ-1:0]     grant_oh;
  logic [DATA_W-1:0]   pick_a, pick_b;
  logic [SEL_W-1:0]    pick_sel;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    pick_oh  = '0;
    grant_oh = '0;
    pick_a   = '0;
    pick_b   = '0;
    pick_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == pick_idx) begin
        pick_oh[i] = 1'b1;
        pick_a     = req_a[i*DATA_W +: DATA_W];
        pick_b     = req_b[i*DATA_W +: DATA_W];
        pick_sel   = req_sel[i*SEL_W +: SEL_W];
      end
      if (IDW'(i) == grant_q) grant_oh[i] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_d     = grant_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so no handshake is advertised while reset is held.
        if (pick_any && rst_n) begin
          req_ready = pick_oh;
          alu_a_d   = pick_a;
          alu_b_d   = pick_b;
          alu_sel_d = pick_sel;
          grant_d   = pick_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_carry_d = alu_carry;
        rsp_valid_d = grant_oh;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          last_d      = grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      grant_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter with a small stand-in ALU; table vectors plus corner sequences.
module tb_alu_rr_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned NR = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR*SW-1:0] req_sel;
  logic [DW-1:0] rsp_data, alu_a, alu_b, alu_out;
  logic [SW-1:0] alu_sel;
  logic          rsp_carry, alu_carry, busy;
  logic [0:0]    grant_id;
  logic [8:0]    alu_tmp;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.DATA_W(DW), .SEL_W(SW), .NREQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy), .grant_id(grant_id)
  );

  // Stand-in ALU: add, sub (carry = borrow), and, or, xor.
  always_comb begin
    alu_tmp = '0;
    case (alu_sel)
      4'h0:    alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1:    alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
      4'h2:    alu_tmp = {1'b0, alu_a & alu_b};
      4'h3:    alu_tmp = {1'b0, alu_a | alu_b};
      4'h4:    alu_tmp = {1'b0, alu_a ^ alu_b};
      default: alu_tmp = '0;
    endcase
  end
  assign alu_out   = alu_tmp[7:0];
  assign alu_carry = alu_tmp[8];

  typedef struct {
    int unsigned idx;
    logic [7:0]  a, b;
    logic [3:0]  sel;
    logic [7:0]  exp_d;
    logic        exp_c;
  } vec_t;

  typedef struct {
    int unsigned id;
    logic [7:0]  d;
    logic        c;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [1:0] oh(input int unsigned id);
    logic [1:0] r;
    r = 2'b01 << id;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int unsigned id, input logic [7:0] d, input logic c);
    exp_t e;
    e.id = id; e.d = d; e.c = c;
    sbq.push_back(e);
  endtask

  task automatic pop_chk();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("rsp_onehot", rsp_valid, oh(e.id));
      chk("rsp_grant_id", grant_id, e.id);
      chk("rsp_data", rsp_data, e.d);
      chk("rsp_carry", rsp_carry, e.c);
    end
  endtask

  task automatic set_ops(input int unsigned id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel);
    req_a[id*DW +: DW]   = a;
    req_b[id*DW +: DW]   = b;
    req_sel[id*SW +: SW] = sel;
  endtask

  // Called at negedge+1 while in RESP: complete handshake and check return to IDLE.
  task automatic collect(input int unsigned id);
    chk("resp_valid", rsp_valid, oh(id));
    rsp_ready[id] = 1'b1;
    pop_chk();
    @(negedge clk);
    rsp_ready = '0;
    #1;
    chk("post_busy", busy, 0);
    chk("post_rsp_valid", rsp_valid, 0);
  endtask

  task automatic do_op(input vec_t v);
    int unsigned waited;
    @(negedge clk);
    set_ops(v.idx, v.a, v.b, v.sel);
    req_valid[v.idx] = 1'b1;
    #1;
    waited = 0;
    while (!req_ready[v.idx] && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    chk("accept_ready", req_ready, oh(v.idx));
    push_exp(v.idx, v.exp_d, v.exp_c);
    @(negedge clk);
    req_valid[v.idx] = 1'b0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_grant_id", grant_id, v.idx);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_alu_a", alu_a, v.a);
    chk("exec_alu_b", alu_b, v.b);
    chk("exec_alu_sel", alu_sel, v.sel);
    @(negedge clk); #1;
    collect(v.idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    vec_t v;
    int unsigned accepts, resps, last_acc, id;
    bit drop;

    vecs[0] = '{0, 8'h08, 8'h09, ALU_ADD, 8'h11, 1'b0};
    vecs[1] = '{1, 8'hFF, 8'h01, ALU_ADD, 8'h00, 1'b1};
    vecs[2] = '{0, 8'h05, 8'h07, ALU_SUB, 8'hFE, 1'b1};
    vecs[3] = '{1, 8'hF0, 8'h0F, 4'h2,    8'h00, 1'b0};
    vecs[4] = '{0, 8'hA5, 8'h5A, 4'h3,    8'hFF, 1'b0};
    vecs[5] = '{1, 8'h3C, 8'h0F, 4'h4,    8'h33, 1'b0};

    // 1: reset with both requesters valid
    rst_n = 1'b0; req_valid = 2'b11; rsp_ready = '0;
    req_a = '0; req_b = '0; req_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_grant_req0", req_ready, 2'b01);
    req_valid = '0;

    // 2,3 and more: table vectors
    for (int i = 0; i < 6; i++) do_op(vecs[i]);

    // 4: both requesters held valid, always ready for responses
    set_ops(0, 8'h03, 8'h04, ALU_ADD);
    set_ops(1, 8'hF0, 8'h20, ALU_ADD);
    rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b11;
    accepts = 0; resps = 0; last_acc = 0; drop = 0;
    for (int unsigned cyc = 0; cyc < 60 && resps < 6; cyc++) begin
      #1;
      if (req_ready != 0) begin
        chk("t4_grant_order", req_ready, oh(accepts % 2));
        if (accepts > 0) chk("t4_gap", cyc - last_acc, 3);
        last_acc = cyc;
        id = req_ready[1] ? 1 : 0;
        if (id == 0) push_exp(0, 8'h07, 1'b0);
        else         push_exp(1, 8'h10, 1'b1);
        accepts++;
        if (accepts == 6) drop = 1;
      end
      if (rsp_valid != 0) begin
        pop_chk();
        resps++;
      end
      @(negedge clk);
      if (drop) req_valid = '0;
    end
    chk("t4_accepts", accepts, 6);
    chk("t4_resps", resps, 6);
    rsp_ready = '0;
    @(negedge clk); #1;
    chk("t4_idle", busy, 0);

    // 5: response stalled in RESP; non-granted rsp_ready must be ignored
    @(negedge clk);
    set_ops(0, 8'h80, 8'h80, ALU_ADD);
    req_valid = 2'b01;
    #1;
    chk("t5_accept", req_ready, 2'b01);
    push_exp(0, 8'h00, 1'b1);
    @(negedge clk);
    set_ops(1, 8'h05, 8'h03, ALU_ADD);
    req_valid = 2'b11;
    rsp_ready = 2'b10;
    #1;
    chk("t5_exec_ready", req_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("t5_hold_valid", rsp_valid, 2'b01);
      chk("t5_hold_data", rsp_data, 8'h00);
      chk("t5_hold_carry", rsp_carry, 1);
      chk("t5_hold_ready", req_ready, 0);
      chk("t5_hold_busy", busy, 1);
    end
    rsp_ready = 2'b01;
    pop_chk();
    @(negedge clk);
    rsp_ready = '0;
    req_valid = 2'b10;
    #1;
    chk("t5_idle_busy", busy, 0);
    chk("t5_next_grant", req_ready, 2'b10);
    push_exp(1, 8'h08, 1'b0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t5_grant_id", grant_id, 1);
    @(negedge clk); #1;
    collect(1);

    // 6: reset during EXEC abandons the op and restarts priority at requester 0
    v = '{0, 8'h01, 8'h02, ALU_ADD, 8'h03, 1'b0};
    do_op(v);
    @(negedge clk);
    set_ops(1, 8'h44, 8'h44, ALU_ADD);
    req_valid = 2'b10;
    #1;
    chk("t6_accept_req1", req_ready, 2'b10);
    @(negedge clk);
    set_ops(0, 8'h22, 8'h11, ALU_ADD);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("t6_exec_busy", busy, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("t6_no_rsp", rsp_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_alu_a", alu_a, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_no_rsp_after", rsp_valid, 0);
    chk("t6_grant_req0", req_ready, 2'b01);
    push_exp(0, 8'h33, 1'b0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("t6_grant_id", grant_id, 0);
    @(negedge clk); #1;
    collect(0);
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
